a2d_rr_sampler: RTL and testbench

- Round-robin sequencer directly upstream of the SPI master: drives its wrt/cmd, consumes its done/rd_data.
- Each period, sweeps channels 0..NUM_CH-1 of an external SPI A2D. Per channel: one command transaction, then one read transaction.
- Stores the 12-bit result of every channel in a local register bank, readable through a select port, and flags each completed conversion.

---
 rtl/a2d_rr_sampler_if.sv | 22 ++
 rtl/a2d_rr_sampler.sv | 165 ++++++++++++++++
 tb/tb_a2d_rr_sampler.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/a2d_rr_sampler_if.sv
// SPI-master handshake bundle between the round-robin sampler and the SPI master.
// The sampler is the master side; the SPI master block is the slave side.
interface a2d_rr_sampler_if;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] rd_data;

    modport master (
        output wrt,
        output cmd,
        input  done,
        input  rd_data
    );

    modport slave (
        input  wrt,
        input  cmd,
        output done,
        output rd_data
    );
endinterface

// File: rtl/a2d_rr_sampler.sv
// Round-robin A2D sampler: periodic sweep of channels through the SPI master,
// one command and one read transaction per channel, results held in a bank.
module a2d_rr_sampler #(
    parameter int NUM_CH = 8,
    parameter int PERIOD = 4096,
    parameter int GAP    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    a2d_rr_sampler_if.master    spi,
    input  logic [2:0]          rd_chnl,
    output logic [11:0]         res,
    output logic [2:0]          res_chnl,
    output logic                cnv_cmplt,
    output logic                ovr
);

    localparam int PW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam int GW = $clog2(GAP + 1);
    localparam logic [PW-1:0] PER_LAST = PW'(PERIOD - 1);
    localparam logic [GW-1:0] GAP_LD   = GW'(GAP);
    localparam logic [2:0]    CH_LAST  = 3'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WAIT_C,
        S_GAP,
        S_RD,
        S_WAIT_R,
        S_NEXT
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    chnl_q, chnl_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [15:0]   cmd_q, cmd_d;
    logic [PW-1:0] per_q, per_d;
    logic          done_ff_q;
    logic          ovr_q, ovr_d;
    logic          cnv_q;
    logic [2:0]    res_chnl_q;
    logic [11:0]   bank_q [8];
    logic          tick;
    logic          xfer_end;
    logic          wr_bank;
    logic          unused_hi;

    assign tick      = en && (per_q == PER_LAST);
    assign xfer_end  = spi.done && !done_ff_q;
    assign unused_hi = &{1'b0, spi.rd_data[15:12]};

    always_comb begin
        per_d = per_q + 1'b1;
        if (!en || tick) begin
            per_d = '0;
        end
    end

    // A tick that finds a sweep in flight is dropped and only flagged.
    always_comb begin
        ovr_d = ovr_q;
        if (!en) begin
            ovr_d = 1'b0;
        end else if (tick && state_q != S_IDLE) begin
            ovr_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        chnl_d  = chnl_q;
        gap_d   = gap_q;
        cmd_d   = cmd_q;
        wr_bank = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (tick) begin
                    state_d = S_CMD;
                    chnl_d  = '0;
                end
            end
            S_CMD: begin
                state_d = S_WAIT_C;
            end
            S_WAIT_C: begin
                if (xfer_end) begin
                    state_d = S_GAP;
                    gap_d   = GAP_LD;
                end
            end
            S_GAP: begin
                if (gap_q == GW'(1)) begin
                    state_d = S_RD;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            S_RD: begin
                state_d = S_WAIT_R;
            end
            S_WAIT_R: begin
                if (xfer_end) begin
                    wr_bank = 1'b1;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (chnl_q == CH_LAST || !en) begin
                    state_d = S_IDLE;
                    chnl_d  = '0;
                end else begin
                    state_d = S_CMD;
                    chnl_d  = chnl_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Load the packet on entry so it is already valid in the wrt cycle.
        if (state_d == S_CMD || state_d == S_RD) begin
            cmd_d = {2'b00, chnl_d, 11'h000};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            chnl_q     <= '0;
            gap_q      <= '0;
            cmd_q      <= '0;
            per_q      <= '0;
            done_ff_q  <= 1'b1;
            ovr_q      <= 1'b0;
            cnv_q      <= 1'b0;
            res_chnl_q <= '0;
            for (int i = 0; i < 8; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            chnl_q    <= chnl_d;
            gap_q     <= gap_d;
            cmd_q     <= cmd_d;
            per_q     <= per_d;
            done_ff_q <= spi.done;
            ovr_q     <= ovr_d;
            cnv_q     <= wr_bank;
            if (wr_bank) begin
                bank_q[chnl_q] <= spi.rd_data[11:0];
                res_chnl_q     <= chnl_q;
            end
        end
    end

    assign spi.wrt   = (state_q == S_CMD) || (state_q == S_RD);
    assign spi.cmd   = cmd_q;
    assign cnv_cmplt = cnv_q;
    assign res_chnl  = res_chnl_q;
    assign ovr       = ovr_q;
    assign res       = (int'(rd_chnl) < NUM_CH) ? bank_q[rd_chnl] : 12'h000;

endmodule

// File: tb/tb_a2d_rr_sampler.sv
// Bench for a2d_rr_sampler: SPI slave model, event monitor and a
// transaction-level scoreboard of the round-robin sweep.
module tb_a2d_rr_sampler;
    localparam int NCH = 8;
    localparam int TPER = 128;
    localparam int TGAP = 2;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [2:0]  rd_chnl;
    logic [11:0] res;
    logic [2:0]  res_chnl;
    logic        cnv_cmplt;
    logic        ovr;

    a2d_rr_sampler_if spi();

    a2d_rr_sampler #(
        .NUM_CH (NCH),
        .PERIOD (TPER),
        .GAP    (TGAP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .spi       (spi),
        .rd_chnl   (rd_chnl),
        .res       (res),
        .res_chnl  (res_chnl),
        .cnv_cmplt (cnv_cmplt),
        .ovr       (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [15:0] cmd;
        int          rise;
    } wev_t;

    typedef struct {
        int         cyc;
        logic [2:0] ch;
        logic       en;
    } cev_t;

    typedef struct {
        logic [2:0]  sel;
        logic [11:0] exp;
    } vec_t;

    wev_t wq[$];
    cev_t cq[$];

    logic [15:0] resp [NCH];
    int lat_lo, lat_hi, drop_hi;

    int checks;
    int errors;

    // SPI slave: done falls the cycle after wrt (optionally later),
    // stays low for a random latency, then rises with the response word.
    initial begin : slave
        int   ph, hi, lo;
        logic seen;
        logic [2:0] cap, sch;
        spi.done    = 1'b1;
        spi.rd_data = 16'h0000;
        ph = 0; hi = 0; lo = 0;
        seen = 1'b0; cap = '0; sch = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                spi.done = 1'b1;
                ph = 0;
                seen = 1'b0;
            end else begin
                if (seen) begin
                    hi  = $urandom_range(drop_hi, 0);
                    lo  = $urandom_range(lat_hi, lat_lo);
                    sch = cap;
                    spi.rd_data = 16'($urandom);
                    if (hi == 0) begin
                        ph = 2;
                        spi.done = 1'b0;
                    end else begin
                        ph = 1;
                    end
                end else if (ph == 1) begin
                    hi--;
                    if (hi == 0) begin
                        ph = 2;
                        spi.done = 1'b0;
                    end
                end else if (ph == 2) begin
                    lo--;
                    if (lo == 0) begin
                        ph = 0;
                        spi.done = 1'b1;
                        spi.rd_data = resp[sch];
                    end
                end
                seen = spi.wrt;
                cap  = spi.cmd[13:11];
            end
        end
    end

    initial begin : monitor
        int   cyc, last_rise;
        logic dprev;
        cyc = 0; last_rise = 0; dprev = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n === 1'b1) begin
                if (spi.done && !dprev) last_rise = cyc;
                if (spi.wrt === 1'b1) wq.push_back('{cyc, spi.cmd, last_rise});
                if (cnv_cmplt === 1'b1) cq.push_back('{cyc, res_chnl, en});
            end
            dprev = spi.done;
        end
    end

    int          exp_ch;
    bit          exp_rd;
    logic [11:0] mbank [NCH];
    int          wi, ci;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_ch = 0;
        exp_rd = 1'b0;
        for (int k = 0; k < NCH; k++) mbank[k] = 12'h000;
    endtask

    // Replays recorded wrt / cnv events in time order against the sweep rules.
    task automatic score();
        while (wi < wq.size() || ci < cq.size()) begin
            if (ci >= cq.size() ||
                (wi < wq.size() && wq[wi].cyc < cq[ci].cyc)) begin
                chk("cmd", {16'h0, wq[wi].cmd},
                    {16'h0, 2'b00, 3'(exp_ch), 11'h000});
                if (exp_rd) chk("gap", wq[wi].cyc - wq[wi].rise, TGAP + 1);
                exp_rd = !exp_rd;
                wi++;
            end else begin
                chk("res_chnl", {29'h0, cq[ci].ch}, exp_ch);
                chk("pair_done", {31'h0, exp_rd}, 0);
                mbank[exp_ch] = resp[exp_ch][11:0];
                if (!cq[ci].en || exp_ch == NCH - 1) exp_ch = 0;
                else exp_ch = exp_ch + 1;
                ci++;
            end
        end
    endtask

    task automatic check_bank();
        for (int k = 0; k < NCH; k++) begin
            rd_chnl = 3'(k);
            #1;
            chk("bank", {20'h0, res}, {20'h0, mbank[k]});
        end
    endtask

    task automatic wait_cnv(input int target, input int budget);
        int n;
        n = 0;
        while (cq.size() < target && n < budget) begin
            cyc_wait(1);
            n++;
        end
        chk("cnv_wait", cq.size() >= target, 1);
    endtask

    task automatic wait_wrt(input int target, input int budget);
        int n;
        n = 0;
        while (wq.size() < target && n < budget) begin
            cyc_wait(1);
            n++;
        end
        chk("wrt_wait", wq.size() >= target, 1);
    endtask

    initial begin : main
        vec_t vt [NCH];
        int   n, bw, bc;
        checks = 0; errors = 0;
        wi = 0; ci = 0;
        lat_lo = 1; lat_hi = 3; drop_hi = 0;
        rst_n = 1'b0; en = 1'b0; rd_chnl = '0;
        for (int k = 0; k < NCH; k++) begin
            resp[k] = (k == 3) ? 16'h0ABC : {4'hF, 9'h0, 3'(k)};
            vt[k].sel = 3'(k);
            vt[k].exp = (k == 3) ? 12'hABC : 12'(k);
        end
        model_reset();

        cyc_wait(3);
        chk("rst_wrt", spi.wrt, 0);
        chk("rst_cmd", spi.cmd, 0);
        chk("rst_cnv", cnv_cmplt, 0);
        chk("rst_ovr", ovr, 0);
        chk("rst_res_chnl", res_chnl, 0);
        check_bank();

        rst_n = 1'b1;
        en = 1'b1;
        n = 0;
        while (!spi.wrt && n < 1000) begin
            cyc_wait(1);
            n++;
        end
        chk("first_wrt_cycle", n, TPER);
        chk("first_cmd", spi.cmd, 16'h0000);

        wait_cnv(NCH, 400);
        cyc_wait(2);
        chk("sweep_wrts", wq.size(), 2 * NCH);
        chk("sweep_cnvs", cq.size(), NCH);
        score();
        for (int i = 0; i < NCH; i++) begin
            rd_chnl = vt[i].sel;
            #1;
            chk("vec_res", {20'h0, res}, {20'h0, vt[i].exp});
        end
        chk("ovr_clean", ovr, 0);

        lat_lo = 1; lat_hi = 2; drop_hi = 1;
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < NCH; k++) resp[k] = 16'($urandom);
            wait_cnv(cq.size() + NCH, 400);
            score();
            check_bank();
            chk("ovr_rand", ovr, 0);
        end

        lat_lo = 4; lat_hi = 4; drop_hi = 0;
        for (int k = 0; k < NCH; k++) resp[k] = 16'($urandom);
        bw = wq.size();
        bc = cq.size();
        wait_wrt(bw + 5, 400);
        en = 1'b0;
        wait_cnv(bc + 3, 200);
        cyc_wait(150);
        chk("endrop_wrts", wq.size(), bw + 6);
        chk("endrop_cnvs", cq.size(), bc + 3);
        chk("endrop_ovr", ovr, 0);
        score();
        check_bank();

        lat_lo = 10; lat_hi = 10;
        bw = wq.size();
        bc = cq.size();
        en = 1'b1;
        n = 0;
        while (!ovr && n < 400) begin
            cyc_wait(1);
            n++;
        end
        chk("ovr_set", ovr, 1);
        wait_cnv(bc + NCH, 600);
        chk("ovr_sticky", ovr, 1);
        cyc_wait(10);
        chk("no_queued_sweep", wq.size(), bw + 2 * NCH);
        en = 1'b0;
        cyc_wait(1);
        chk("ovr_clear", ovr, 0);
        score();

        lat_lo = 3; lat_hi = 3;
        bw = wq.size();
        en = 1'b1;
        wait_wrt(bw + 12, 400);
        rst_n = 1'b0;
        cyc_wait(1);
        chk("mrst_wrt", spi.wrt, 0);
        chk("mrst_cmd", spi.cmd, 0);
        chk("mrst_cnv", cnv_cmplt, 0);
        chk("mrst_ovr", ovr, 0);
        chk("mrst_res_chnl", res_chnl, 0);
        score();
        model_reset();
        for (int k = 0; k < NCH; k++) begin
            rd_chnl = 3'(k);
            #1;
            chk("mrst_bank", {20'h0, res}, 0);
        end
        en = 1'b0;
        rst_n = 1'b1;
        bw = wq.size();
        cyc_wait(20);
        chk("idle_after_rst", wq.size(), bw);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
